// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
//
// Generic inter-stage pipeline register with a valid/ready handshake, an
// ExcCode / branch-delay sideband and an optional skid entry.
//
// Two entries are kept:
//   M (main) - drives the outputs directly.
//   S (skid) - present when SKID=1; catches the beat that was already
//              accepted while M was stalled, so a stalled downstream stage
//              never drops data and in_ready does not depend on out_ready.
//
// Control priority per edge: reset > req (full clear) > flush (drop the input
// beat only) > normal transfer. Invalid entries always hold an all-zero
// payload (nop).
//
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous, active-high reset
//   req        - exception/interrupt entry: clears M and S, drops input
//   flush      - kills this cycle's input beat; held entries are kept
//   in_valid   - upstream beat valid
//   in_ready   - stage can accept a beat (combinational)
//   in_data    - upstream payload          [DATA_W]
//   in_exc     - upstream ExcCode          [EXC_W]
//   in_bd      - upstream branch-delay flag
//   out_valid  - main entry valid
//   out_ready  - downstream accepts this cycle
//   out_data   - main entry payload        [DATA_W]
//   out_exc    - main entry ExcCode        [EXC_W]
//   out_bd     - main entry BD flag
//   stall_cnt  - saturating count of cycles with out_valid & ~out_ready
//   bubble_cnt - saturating count of cycles with ~out_valid
// -----------------------------------------------------------------------------
module pipe_skid_stage #(
    parameter int DATA_W = 160,
    parameter int EXC_W  = 5,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              in_bd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_bd,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Saturating increment: stops at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] cnt,
        input logic             en
    );
        logic [CNT_W-1:0] res;
        if (en && (cnt != {CNT_W{1'b1}})) begin
            res = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    // Main entry
    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q,  m_data_d;
    logic [EXC_W-1:0]  m_exc_q,   m_exc_d;
    logic              m_bd_q,    m_bd_d;

    // Skid entry (never loaded when SKID=0, so it stays cleared)
    logic              s_valid_q, s_valid_d;
    logic [DATA_W-1:0] s_data_q,  s_data_d;
    logic [EXC_W-1:0]  s_exc_q,   s_exc_d;
    logic              s_bd_q,    s_bd_d;

    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic              fire_in_s;

    // With a skid entry the ready depends only on registered state, which
    // breaks the combinational ready path through the stage.
    assign in_ready  = (SKID != 0) ? ~s_valid_q : (~m_valid_q | out_ready);
    assign fire_in_s = in_valid & in_ready & ~flush & ~req;

    assign out_valid  = m_valid_q;
    assign out_data   = m_data_q;
    assign out_exc    = m_exc_q;
    assign out_bd     = m_bd_q;
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

    // Next-state for M and S entries.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_exc_d   = m_exc_q;
        m_bd_d    = m_bd_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        s_exc_d   = s_exc_q;
        s_bd_d    = s_bd_q;

        if (req) begin
            // Exception entry: everything in flight is discarded at once.
            m_valid_d = 1'b0;
            m_data_d  = {DATA_W{1'b0}};
            m_exc_d   = {EXC_W{1'b0}};
            m_bd_d    = 1'b0;
            s_valid_d = 1'b0;
            s_data_d  = {DATA_W{1'b0}};
            s_exc_d   = {EXC_W{1'b0}};
            s_bd_d    = 1'b0;
        end else if (!m_valid_q) begin
            // S is never valid while M is empty, so only M can load here.
            if (fire_in_s) begin
                m_valid_d = 1'b1;
                m_data_d  = in_data;
                m_exc_d   = in_exc;
                m_bd_d    = in_bd;
            end else begin
                m_valid_d = m_valid_q;
            end
        end else if (out_ready) begin
            if (s_valid_q) begin
                // S is older than any new input; it must go next.
                m_valid_d = 1'b1;
                m_data_d  = s_data_q;
                m_exc_d   = s_exc_q;
                m_bd_d    = s_bd_q;
                s_valid_d = 1'b0;
                s_data_d  = {DATA_W{1'b0}};
                s_exc_d   = {EXC_W{1'b0}};
                s_bd_d    = 1'b0;
            end else if (fire_in_s) begin
                m_valid_d = 1'b1;
                m_data_d  = in_data;
                m_exc_d   = in_exc;
                m_bd_d    = in_bd;
            end else begin
                m_valid_d = 1'b0;
                m_data_d  = {DATA_W{1'b0}};
                m_exc_d   = {EXC_W{1'b0}};
                m_bd_d    = 1'b0;
            end
        end else begin
            // M stalled: an accepted beat can only land in S.
            if (fire_in_s && (SKID != 0)) begin
                s_valid_d = 1'b1;
                s_data_d  = in_data;
                s_exc_d   = in_exc;
                s_bd_d    = in_bd;
            end else begin
                s_valid_d = s_valid_q;
            end
        end
    end

    // Next-state for the performance counters (also run during req).
    always_comb begin
        stall_cnt_d  = sat_inc(stall_cnt_q, m_valid_q & ~out_ready);
        bubble_cnt_d = sat_inc(bubble_cnt_q, ~m_valid_q);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_q    <= 1'b0;
            m_data_q     <= {DATA_W{1'b0}};
            m_exc_q      <= {EXC_W{1'b0}};
            m_bd_q       <= 1'b0;
            s_valid_q    <= 1'b0;
            s_data_q     <= {DATA_W{1'b0}};
            s_exc_q      <= {EXC_W{1'b0}};
            s_bd_q       <= 1'b0;
            stall_cnt_q  <= {CNT_W{1'b0}};
            bubble_cnt_q <= {CNT_W{1'b0}};
        end else begin
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_exc_q      <= m_exc_d;
            m_bd_q       <= m_bd_d;
            s_valid_q    <= s_valid_d;
            s_data_q     <= s_data_d;
            s_exc_q      <= s_exc_d;
            s_bd_q       <= s_bd_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: a SKID=1 instance for the main tests
// and a SKID=0, CNT_W=2 instance for pass-through and counter saturation.
module tb_pipe_skid_stage;

    localparam int DW = 32;
    localparam int EW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // SKID=1 instance signals
    logic          reset, req, flush, in_valid, in_ready, in_bd;
    logic          out_valid, out_ready, out_bd;
    logic [DW-1:0] in_data, out_data;
    logic [EW-1:0] in_exc, out_exc;
    logic [15:0]   stall_cnt, bubble_cnt;

    // SKID=0 instance signals
    logic          reset0, req0, flush0, in_valid0, in_ready0, in_bd0;
    logic          out_valid0, out_ready0, out_bd0;
    logic [DW-1:0] in_data0, out_data0;
    logic [EW-1:0] in_exc0, out_exc0;
    logic [1:0]    stall_cnt0, bubble_cnt0;

    pipe_skid_stage #(.DATA_W(DW), .EXC_W(EW), .SKID(1), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .req(req), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_exc(in_exc), .in_bd(in_bd),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_exc(out_exc), .out_bd(out_bd),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_skid_stage #(.DATA_W(DW), .EXC_W(EW), .SKID(0), .CNT_W(2)) u_dut0 (
        .clk(clk), .reset(reset0), .req(req0), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .in_exc(in_exc0), .in_bd(in_bd0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .out_exc(out_exc0), .out_bd(out_bd0),
        .stall_cnt(stall_cnt0), .bubble_cnt(bubble_cnt0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_data = 32'h0; in_exc = 5'h0; in_bd = 1'b0; out_ready = 1'b0;
        reset0 = 1'b1; req0 = 1'b0; flush0 = 1'b0; in_valid0 = 1'b0;
        in_data0 = 32'h0; in_exc0 = 5'h0; in_bd0 = 1'b0; out_ready0 = 1'b0;

        // Reset then idle for 10 cycles
        tick();
        reset = 1'b0;
        repeat (10) tick();
        chk("idle_out_valid", out_valid, 64'h0);
        chk("idle_out_data", out_data, 64'h0);
        chk("idle_in_ready", in_ready, 64'h1);
        chk("idle_bubble", bubble_cnt, 64'd10);
        chk("idle_stall", stall_cnt, 64'd0);

        // Streaming 1..4 with out_ready high
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 32'(i);
            tick();
            chk("stream_valid", out_valid, 64'h1);
            chk("stream_data", out_data, 64'(i));
            chk("stream_in_ready", in_ready, 64'h1);
        end
        in_valid = 1'b0; in_data = 32'h0;
        tick();
        chk("stream_drain_valid", out_valid, 64'h0);
        chk("stream_bubble", bubble_cnt, 64'd11);

        // Backpressure into the skid entry
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        tick();
        chk("bp_m_a", out_data, 64'hA);
        chk("bp_ready_1", in_ready, 64'h1);
        in_data = 32'hB;
        tick();
        chk("bp_hold_a", out_data, 64'hA);
        chk("bp_full_ready", in_ready, 64'h0);
        in_data = 32'hC;
        tick();
        chk("bp_still_a", out_data, 64'hA);
        chk("bp_c_blocked", in_ready, 64'h0);
        out_ready = 1'b1;
        tick();
        chk("bp_out_b", out_data, 64'hB);
        chk("bp_ready_again", in_ready, 64'h1);
        tick();
        chk("bp_out_c", out_data, 64'hC);
        in_valid = 1'b0; in_data = 32'h0;
        tick();
        chk("bp_drained", out_valid, 64'h0);
        chk("bp_stall", stall_cnt, 64'd2);

        // Flush with M empty
        in_valid = 1'b1; in_data = 32'h55; flush = 1'b1;
        tick();
        chk("flush_empty_valid", out_valid, 64'h0);
        chk("flush_empty_data", out_data, 64'h0);
        // Flush with M=0x77 held under backpressure
        flush = 1'b0; in_data = 32'h77; out_ready = 1'b0;
        tick();
        chk("flush_load77", out_data, 64'h77);
        flush = 1'b1; in_data = 32'h99;
        tick();
        chk("flush_hold77", out_data, 64'h77);
        chk("flush_hold_valid", out_valid, 64'h1);
        chk("flush_no_skid", in_ready, 64'h1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("flush_drain", out_valid, 64'h0);

        // req with both entries full
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'h11; in_exc = 5'd4; in_bd = 1'b0;
        tick();
        chk("req_m_exc", out_exc, 64'd4);
        in_data = 32'h22; in_exc = 5'd0; in_bd = 1'b1;
        tick();
        chk("req_full", in_ready, 64'h0);
        req = 1'b1;
        tick();
        chk("req_valid", out_valid, 64'h0);
        chk("req_exc", out_exc, 64'h0);
        chk("req_bd", out_bd, 64'h0);
        chk("req_data", out_data, 64'h0);
        chk("req_in_ready", in_ready, 64'h1);
        req = 1'b0; in_valid = 1'b0; in_bd = 1'b0; out_ready = 1'b1;
        tick();
        chk("req_skid_dropped", out_valid, 64'h0);

        // Reset mid-transfer wins
        in_valid = 1'b1; in_data = 32'h33;
        tick();
        chk("rst_mid_load", out_data, 64'h33);
        reset = 1'b1;
        tick();
        chk("rst_mid_valid", out_valid, 64'h0);
        chk("rst_mid_data", out_data, 64'h0);
        chk("rst_mid_stall", stall_cnt, 64'h0);
        chk("rst_mid_bubble", bubble_cnt, 64'h0);
        reset = 1'b0; in_valid = 1'b0;

        // SKID=0: pass-through then saturating stall counter
        reset0 = 1'b0; out_ready0 = 1'b1; in_valid0 = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data0 = 32'(i);
            tick();
            chk("s0_pass_valid", out_valid0, 64'h1);
            chk("s0_pass_data", out_data0, 64'(i));
            chk("s0_pass_ready", in_ready0, 64'h1);
        end
        chk("s0_exc", out_exc0, 64'h0);
        chk("s0_bd", out_bd0, 64'h0);
        out_ready0 = 1'b0; in_data0 = 32'h9;
        #1;
        chk("s0_stall_ready", in_ready0, 64'h0);
        repeat (6) tick();
        chk("s0_stall_sat", stall_cnt0, 64'd3);
        chk("s0_hold_data", out_data0, 64'h3);
        chk("s0_bubble", bubble_cnt0, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
